// File: rtl/poly_decompress_unpack.sv
// Unpacks a LSB-first stream of d-bit compressed coefficients, decompresses each
// to a 12-bit value mod 3329 and emits them in pairs as {odd, even} 24-bit words.
module poly_decompress_unpack #(
    parameter int BUF_W = 32,
    parameter int NCOEF = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  d_sel,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);
    localparam int CW = $clog2(BUF_W + 1);
    localparam int NW = $clog2(NCOEF + 1);
    localparam int WW = $clog2(NCOEF / 2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_next;
    logic [3:0]       d, d_dec;
    logic [BUF_W-1:0] bit_buf, buf_shift, buf_next;
    logic [CW-1:0]    cnt, cnt_next, app_pos;
    logic [8:0]       bytes_taken;
    logic [NW-1:0]    coef_cnt;
    logic [WW-1:0]    word_cnt;
    logic             s1_valid, s1_odd;
    logic [11:0]      s1_coef, even_hold;
    logic             run, take, extract, s2_load, stall, out_hs, last_hs;
    logic [11:0]      x, y;
    logic [23:0]      prod;

    always_comb begin
        case (d_sel)
            3'd0:    d_dec = 4'd1;
            3'd1:    d_dec = 4'd4;
            3'd2:    d_dec = 4'd5;
            3'd3:    d_dec = 4'd10;
            3'd4:    d_dec = 4'd11;
            default: d_dec = 4'd12;
        endcase
    end

    // Handshakes: a transfer happens on the clock edge where valid & ready are both high.
    assign run      = (state == RUN);
    assign in_ready = run && (32'(cnt) + 32'd8 <= BUF_W) && (bytes_taken < {d, 5'b0});
    assign take     = in_ready && in_valid;
    assign out_hs   = out_valid && out_ready;
    assign last_hs  = out_hs && (word_cnt == WW'(NCOEF / 2 - 1));
    // Only an odd coefficient needs the output register, so only it can stall the pipe.
    assign s2_load  = s1_valid && s1_odd;
    assign stall    = out_valid && !out_ready && s2_load;
    assign extract  = run && (cnt >= CW'(d)) && !stall && (coef_cnt < NW'(NCOEF));

    // For d=12 the mask shift wraps to zero, leaving all 12 bits selected.
    assign x    = bit_buf[11:0] & ((12'd1 << d) - 12'd1);
    assign prod = 24'(x) * 24'd3329 + (24'd1 << (d - 4'd1));
    assign y    = (d == 4'd12) ? x : 12'(prod >> d);

    assign buf_shift = extract ? (bit_buf >> d) : bit_buf;
    assign app_pos   = extract ? (cnt - CW'(d)) : cnt;
    assign buf_next  = take ? (buf_shift | (BUF_W'(in_byte) << app_pos)) : buf_shift;
    assign cnt_next  = cnt + (take ? CW'(8) : CW'(0)) - (extract ? CW'(d) : CW'(0));

    assign busy      = run;
    assign done      = (state == DONE);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_hs) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d           <= 4'd0;
            bit_buf     <= '0;
            cnt         <= '0;
            bytes_taken <= '0;
            coef_cnt    <= '0;
            word_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_odd      <= 1'b0;
            s1_coef     <= '0;
            even_hold   <= '0;
            out_word    <= '0;
            out_valid   <= 1'b0;
        end else if (state == IDLE && start) begin
            d           <= d_dec;
            bit_buf     <= '0;
            cnt         <= '0;
            bytes_taken <= '0;
            coef_cnt    <= '0;
            word_cnt    <= '0;
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
        end else if (run) begin
            bit_buf     <= buf_next;
            cnt         <= cnt_next;
            bytes_taken <= bytes_taken + {8'd0, take};
            coef_cnt    <= coef_cnt + {{(NW-1){1'b0}}, extract};
            word_cnt    <= word_cnt + {{(WW-1){1'b0}}, out_hs};
            if (!stall) begin
                s1_valid <= extract;
                s1_coef  <= y;
                s1_odd   <= coef_cnt[0];
            end
            if (s1_valid && !s1_odd) even_hold <= s1_coef;
            if (s2_load && !stall) begin
                out_word  <= {s1_coef, even_hold};
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_poly_decompress_unpack.sv
// Directed bench for poly_decompress_unpack: hand-computed words per compression width,
// backpressure, mid-polynomial reset and ignored start / idle input.
module tb_poly_decompress_unpack;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  d_sel;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [1:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_taken;
    int n_done;

    logic [7:0]  stim[$];
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [23:0] ref_q[$];
    int          coef_in[$];

    poly_decompress_unpack #(.BUF_W(32), .NCOEF(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_decomp(input int d, input int x);
        if (d == 12) return x;
        return (x * 3329 + (1 << (d - 1))) >> d;
    endfunction

    task automatic pack_coefs(input int d);
        logic [63:0] acc;
        int n;
        acc = '0;
        n = 0;
        stim.delete();
        foreach (coef_in[i]) begin
            acc = acc | (64'(coef_in[i]) << n);
            n = n + d;
            while (n >= 8) begin
                stim.push_back(acc[7:0]);
                acc = acc >> 8;
                n = n - 8;
            end
        end
    endtask

    task automatic compare_words(input string tg);
        int n;
        check($sformatf("%s_nwords", tg), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tg, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_poly(input string tg, input logic [2:0] dsel, input bit rand_ready,
                            input int abort_at, input bit poke_start);
        int cyc;
        got_q.delete();
        n_taken = 0;
        n_done = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        d_sel = dsel;
        @(negedge clk);
        start = 1'b0;
        d_sel = 3'd0;
        check($sformatf("%s_busy_on", tg), busy, 1);
        while (cyc < 4000) begin
            if (done) n_done++;
            if (n_done != 0) break;
            in_valid  = 1'b1;
            in_byte   = (n_taken < stim.size()) ? stim[n_taken] : 8'hEE;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke_start && (cyc == 20);
            #1;
            if (in_valid && in_ready) n_taken++;
            if (out_valid && out_ready) got_q.push_back(out_word);
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                in_valid = 1'b0;
                #1;
                check($sformatf("%s_rst_ovalid", tg), out_valid, 0);
                check($sformatf("%s_rst_word", tg), out_word, 0);
                check($sformatf("%s_rst_busy", tg), busy, 0);
                check($sformatf("%s_rst_inrdy", tg), in_ready, 0);
                check($sformatf("%s_rst_state", tg), fsm_state, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (done) n_done++;
                end
                rst_n = 1'b1;
                @(negedge clk);
                if (done) n_done++;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s_busy_at_done", tg), busy, 0);
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'hEE;
            #1;
            if (done) n_done++;
            check($sformatf("%s_inrdy_after", tg), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; d_sel = 3'd0;
        in_byte = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inrdy", in_ready, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_word", out_word, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", fsm_state, 0);
        rst_n = 1'b1;

        // Bytes offered while idle must not be taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte = 8'h55;
            #1;
            check("idle_inrdy", in_ready, 0);
        end
        in_valid = 1'b0;

        // d=1, 0xA5: bits 1,0,1,0,0,1,0,1 -> coef 1665 / 0.
        stim.delete(); exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            stim.push_back(8'hA5);
            exp_q.push_back(24'h000681); exp_q.push_back(24'h000681);
            exp_q.push_back(24'h681000); exp_q.push_back(24'h681000);
        end
        run_poly("t1", 3'd0, 1'b0, -1, 1'b0);
        compare_words("t1");
        check("t1_bytes", n_taken, 32);
        check("t1_done", n_done, 1);

        // d=4, 0xFF: every coefficient 3121.
        stim.delete(); exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            stim.push_back(8'hFF);
            exp_q.push_back(24'hC31C31);
        end
        run_poly("t2", 3'd1, 1'b0, -1, 1'b0);
        compare_words("t2");
        check("t2_bytes", n_taken, 128);
        check("t2_done", n_done, 1);

        // d=10, 1023/0 alternating -> {0, 3326}.
        coef_in.delete(); exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            coef_in.push_back(1023); coef_in.push_back(0);
            exp_q.push_back(24'h000CFE);
        end
        pack_coefs(10);
        run_poly("t3a", 3'd3, 1'b0, -1, 1'b0);
        compare_words("t3a");
        check("t3a_bytes", n_taken, 320);
        check("t3a_done", n_done, 1);

        // d=11, all ones -> 3327.
        stim.delete(); exp_q.delete();
        for (int i = 0; i < 352; i++) stim.push_back(8'hFF);
        for (int i = 0; i < 128; i++) exp_q.push_back(24'hCFFCFF);
        run_poly("t3b", 3'd4, 1'b0, -1, 1'b0);
        compare_words("t3b");
        check("t3b_bytes", n_taken, 352);
        check("t3b_done", n_done, 1);

        // d=12 raw: three bytes form one word little-endian; then under random stall.
        stim.delete(); exp_q.delete();
        stim.push_back(8'h01); stim.push_back(8'h23); stim.push_back(8'h45);
        for (int i = 3; i < 384; i++) stim.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 128; i++)
            exp_q.push_back({stim[3*i+2], stim[3*i+1], stim[3*i]});
        run_poly("t4a", 3'd7, 1'b0, -1, 1'b0);
        if (got_q.size() > 0) check("t4a_first", got_q[0], 24'h452301);
        compare_words("t4a");
        check("t4a_bytes", n_taken, 384);
        check("t4a_done", n_done, 1);
        ref_q = got_q;
        run_poly("t4b", 3'd7, 1'b1, -1, 1'b0);
        compare_words("t4b");
        check("t4b_nsame", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            check($sformatf("t4b_same%0d", i), got_q[i], ref_q[i]);
        check("t4b_bytes", n_taken, 384);
        check("t4b_done", n_done, 1);

        // d=5 polynomial aborted by reset at word 40, then a fresh one.
        coef_in.delete();
        for (int i = 0; i < 256; i++) coef_in.push_back($urandom_range(0, 31));
        pack_coefs(5);
        run_poly("t5a", 3'd2, 1'b0, 40, 1'b0);
        check("t5a_words", got_q.size(), 40);
        check("t5a_nodone", n_done, 0);
        coef_in.delete(); exp_q.delete();
        for (int i = 0; i < 256; i++) coef_in.push_back(i % 32);
        for (int i = 0; i < 128; i++)
            exp_q.push_back({12'(ref_decomp(5, (2*i+1) % 32)), 12'(ref_decomp(5, (2*i) % 32))});
        pack_coefs(5);
        run_poly("t5b", 3'd2, 1'b0, -1, 1'b0);
        if (got_q.size() > 15) begin
            check("t5b_w0", got_q[0], {12'd104, 12'd0});
            check("t5b_w15", got_q[15], {12'd3225, 12'd3121});
        end
        compare_words("t5b");
        check("t5b_bytes", n_taken, 160);
        check("t5b_done", n_done, 1);

        // d=4 with a start (d_sel=d=1) poked mid-run: must be ignored.
        stim.delete(); exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            stim.push_back(8'h0F);
            exp_q.push_back(24'h000C31);
        end
        run_poly("t6", 3'd1, 1'b0, -1, 1'b1);
        compare_words("t6");
        check("t6_bytes", n_taken, 128);
        check("t6_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
